// File: rtl/dsram_like_responder.sv
// dsram_like_responder: fixed-latency sram-like data memory responder with byte write enables
module dsram_like_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        pipe_stall,
  output logic [31:0] mem_rdata,
  output logic        data_stall,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [ADDR_W-1:0] req_idx, a_idx;
  logic [3:0] req_wen, a_wen;
  logic [31:0] req_wdata, a_wdata;
  logic [31:0] ram [2**ADDR_W];
  logic go, cap;
  logic unused_addr;
  assign unused_addr = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};
  assign busy = state != IDLE;
  assign a_idx   = state == IDLE ? mem_addr[ADDR_W+1:2] : req_idx;
  assign a_wen   = state == IDLE ? mem_wen : req_wen;
  assign a_wdata = state == IDLE ? mem_wdata : req_wdata;
  // next state, wait counter and stall; go marks the edge that enters RESP and performs the access
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    cap = 1'b0;
    go = 1'b0;
    data_stall = 1'b0;
    case (state)
      IDLE: begin
        data_stall = mem_en;
        cap = mem_en;
        if (mem_en) begin
          go = LATENCY == 1;
          state_n = LATENCY == 1 ? RESP : WAIT;
          cnt_n = LATENCY == 1 ? cnt : 4'(LATENCY - 2);
        end
      end
      WAIT: begin
        data_stall = 1'b1;
        go = cnt == 4'd0;
        state_n = go ? RESP : WAIT;
        cnt_n = go ? cnt : cnt - 4'd1;
      end
      RESP: state_n = (!pipe_stall || !mem_en) ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
    if (rst) data_stall = 1'b0;
  end
  // state, captured request and response data
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      req_idx <= '0;
      req_wen <= '0;
      req_wdata <= '0;
      mem_rdata <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (cap) begin
        req_idx <= mem_addr[ADDR_W+1:2];
        req_wen <= mem_wen;
        req_wdata <= mem_wdata;
      end
      if (go) mem_rdata <= |a_wen ? 32'd0 : ram[a_idx];
    end
  end
  // byte-lane RAM write; contents survive reset, a write interrupted by reset is dropped
  always_ff @(posedge clk) begin
    if (go && !rst)
      for (int b = 0; b < 4; b++)
        if (a_wen[b]) ram[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_dsram_like_responder.sv
// tb_dsram_like_responder: directed checks of the responder at LATENCY 3 and LATENCY 1
module tb_dsram_like_responder;
  logic clk = 1'b0;
  logic rst;
  logic en3, ps3, st3, bz3;
  logic [3:0] wen3;
  logic [31:0] addr3, wd3, rd3;
  logic en1, ps1, st1, bz1;
  logic [3:0] wen1;
  logic [31:0] addr1, wd1, rd1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  dsram_like_responder #(.ADDR_W(10), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst), .mem_en(en3), .mem_wen(wen3), .mem_addr(addr3),
    .mem_wdata(wd3), .pipe_stall(ps3), .mem_rdata(rd3), .data_stall(st3), .busy(bz3)
  );
  dsram_like_responder #(.ADDR_W(10), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .mem_en(en1), .mem_wen(wen1), .mem_addr(addr1),
    .mem_wdata(wd1), .pipe_stall(ps1), .mem_rdata(rd1), .data_stall(st1), .busy(bz1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req3(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d, input string tag);
    en3 = 1'b1; wen3 = w; addr3 = a; wd3 = d;
    #1 chk({tag, "_stall_t0"}, 32'(st3), 32'd1);
    step(); chk({tag, "_stall_t1"}, 32'(st3), 32'd1); chk({tag, "_busy_t1"}, 32'(bz3), 32'd1);
    step(); chk({tag, "_stall_t2"}, 32'(st3), 32'd1);
    step(); chk({tag, "_stall_t3"}, 32'(st3), 32'd0); chk({tag, "_busy_t3"}, 32'(bz3), 32'd1);
  endtask
  initial begin
    rst = 1'b1;
    en3 = 1'b1; wen3 = 4'd0; addr3 = 32'd0; wd3 = 32'd0; ps3 = 1'b0;
    en1 = 1'b0; wen1 = 4'd0; addr1 = 32'd0; wd1 = 32'd0; ps1 = 1'b0;
    step(); step();
    chk("rst_stall", 32'(st3), 32'd0);
    chk("rst_rdata", rd3, 32'd0);
    chk("rst_busy", 32'(bz3), 32'd0);
    rst = 1'b0; en3 = 1'b0;
    #1 chk("idle_stall_en0", 32'(st3), 32'd0);
    en3 = 1'b1;
    #1 chk("idle_stall_en1", 32'(st3), 32'd1);
    en3 = 1'b0;
    u3.ram[4] = 32'h12345678;
    u3.ram[1] = 32'hAABBCCDD;
    u3.ram[3] = 32'h0BADF00D;
    u1.ram[4] = 32'h12345678;
    step();
    req3(4'd0, 32'h10, 32'd0, "rd");
    chk("rd_data", rd3, 32'h12345678);
    en3 = 1'b0;
    step(); chk("rd_busy_after", 32'(bz3), 32'd0);
    req3(4'b0101, 32'h4, 32'h11223344, "bw");
    chk("bw_rdata_zero", rd3, 32'd0);
    en3 = 1'b0;
    step();
    req3(4'd0, 32'h4, 32'd0, "bwrd");
    chk("bw_merged", rd3, 32'hAA22CC44);
    en3 = 1'b0;
    step();
    ps3 = 1'b1;
    req3(4'd0, 32'h10, 32'd0, "ps");
    chk("ps_data", rd3, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      wen3 = 4'hF; addr3 = 32'h4; wd3 = 32'hFFFFFFFF;
      step();
      chk("ps_hold_stall", 32'(st3), 32'd0);
      chk("ps_hold_data", rd3, 32'h12345678);
      chk("ps_hold_busy", 32'(bz3), 32'd1);
    end
    chk("ps_ram_untouched", u3.ram[1], 32'hAA22CC44);
    ps3 = 1'b0; wen3 = 4'd0; addr3 = 32'h10;
    step();
    chk("ps_exit_busy", 32'(bz3), 32'd0);
    chk("ps_exit_stall", 32'(st3), 32'd1);
    en3 = 1'b0;
    step();
    en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h8; wd3 = 32'hDEADBEEF;
    #1 chk("fl_stall_t0", 32'(st3), 32'd1);
    step(); en3 = 1'b0; wen3 = 4'd0; addr3 = 32'h4;
    #1 chk("fl_stall_t1", 32'(st3), 32'd1);
    step(); chk("fl_stall_t2", 32'(st3), 32'd1);
    step(); chk("fl_stall_t3", 32'(st3), 32'd0); chk("fl_resp_busy", 32'(bz3), 32'd1); chk("fl_rdata", rd3, 32'd0);
    step(); chk("fl_resp_one_cycle", 32'(bz3), 32'd0);
    req3(4'd0, 32'h8, 32'd0, "flrd");
    chk("fl_committed", rd3, 32'hDEADBEEF);
    en3 = 1'b0;
    step();
    en3 = 1'b1; wen3 = 4'hF; addr3 = 32'hC; wd3 = 32'h00000055;
    step(); rst = 1'b1; en3 = 1'b0;
    step(); rst = 1'b0;
    chk("mrst_busy", 32'(bz3), 32'd0);
    chk("mrst_rdata", rd3, 32'd0);
    step();
    req3(4'd0, 32'hC, 32'd0, "mrrd");
    chk("mrst_write_dropped", rd3, 32'h0BADF00D);
    en3 = 1'b0;
    en1 = 1'b1; wen1 = 4'd0; addr1 = 32'h1010;
    #1 chk("l1_stall_0", 32'(st1), 32'd1);
    step(); chk("l1_stall_1", 32'(st1), 32'd0); chk("l1_alias_rd", rd1, 32'h12345678);
    wen1 = 4'hF; addr1 = 32'h1014; wd1 = 32'hCAFEF00D;
    step(); chk("l1_stall_2", 32'(st1), 32'd1);
    step(); chk("l1_stall_3", 32'(st1), 32'd0); chk("l1_wr_rdata", rd1, 32'd0);
    wen1 = 4'd0; addr1 = 32'h14;
    step(); chk("l1_stall_4", 32'(st1), 32'd1);
    step(); chk("l1_stall_5", 32'(st1), 32'd0); chk("l1_rdback", rd1, 32'hCAFEF00D);
    en1 = 1'b0;
    step(); chk("l1_idle_busy", 32'(bz1), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsram_like_responder.md
# dsram_like_responder

Data-side sram-like responder for the MIPS core's memory port. It accepts one request at a time (enable, byte write-enables, address, write data) and holds the core's data stall high for a fixed number of wait states. It then performs the access against an internal word-addressed RAM and returns read data. It sits at the far end of the core's data interface and serves as a latency-configurable memory model, both for the core bench and for FPGA bring-up without the AXI bridge.

## Interface
- ADDR_W, 10: log2 of RAM depth in 32-bit words.
- LATENCY, 3: stall cycles per request; legal range 1..15.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_en  in  1  request valid; core holds it, and the fields below, while stalled.
- mem_wen  in  4  byte write enables; 0 = read, nonzero = write; bit i covers data[8i+7:8i].
- mem_addr  in  32  byte address; word index = mem_addr[ADDR_W+1:2]; other bits ignored.
- mem_wdata  in  32  write data, byte lanes already aligned by the core.
- pipe_stall  in  1  core memory stage frozen for reasons other than this block.
- mem_rdata  out  32  read data; valid in RESP.
- data_stall  out  1  core must hold the memory-stage request.
- busy  out  1  high in WAIT or RESP.

## Operation
- States: IDLE, WAIT, RESP. A 4-bit down-counter `cnt` drives WAIT.
- IDLE:
  - data_stall = mem_en, combinational.
  - On mem_en=1, capture addr/wen/wdata into request registers.
  - If LATENCY=1, next state is RESP; otherwise set cnt=LATENCY-2 and enter WAIT.
- WAIT:
  - data_stall=1.
  - Live inputs are ignored; only captured values are used.
  - cnt>0: decrement. cnt==0: enter RESP.
- Access execution, on the edge entering RESP:
  - Read: mem_rdata <= RAM[idx].
  - Write: RAM[idx] byte lanes with wen=1 <= wdata lanes; other lanes unchanged; mem_rdata <= 0.
- RESP:
  - data_stall=0.
  - mem_rdata is held constant for the whole time in RESP.
  - Exit to IDLE when pipe_stall=0 or mem_en=0. Otherwise stay in RESP. The response is never repeated or re-issued.
- Back-to-back: the core advances on the RESP exit edge. Its next request is seen in IDLE on the following cycle and costs LATENCY stall cycles again.
- Abandoned request: mem_en dropping in WAIT (exception flush) does not cancel. A captured write still commits, and RESP is entered and exits after one cycle.
- The RAM is not cleared by reset. Contents are X/undefined until written. Only the bench may preload via hierarchical init.

## Timing
- Reset values:
  - state=IDLE, cnt=0, mem_rdata=0, busy=0, request registers=0.
  - data_stall is forced to 0 while rst=1, regardless of mem_en.
- Request first seen in cycle T (IDLE, mem_en=1):
  - data_stall=1 in cycles T..T+LATENCY-1.
  - data_stall=0 and mem_rdata valid in cycle T+LATENCY.
  - The write is visible to a read issued at T+LATENCY+1 or later.
- busy is registered state: high from T+1 until the cycle after RESP exit.
- Reset asserted mid-transaction:
  - Return to IDLE on that edge.
  - A write that has not yet entered RESP is dropped.
  - mem_rdata is cleared.
- mem_wen changing after capture has no effect. Misaligned low address bits are ignored, never faulted.
- Address bits above ADDR_W+1 alias: wrap modulo 2^ADDR_W words.

## Test plan
- Reset: rst=1 with mem_en=1 -> data_stall=0, mem_rdata=0, busy=0. After release, IDLE with data_stall=mem_en.
- LATENCY=3 read:
  - Preload RAM[4]=0x12345678; mem_en=1, wen=0, addr=0x10 at T.
  - Expect data_stall high T..T+2, low at T+3, mem_rdata=0x12345678 at T+3.
- Byte write:
  - RAM[1]=0xAABBCCDD; write addr=0x4, wen=4'b0101, wdata=0x11223344.
  - Expect mem_rdata=0 in RESP; a following read returns 0xAA22CC44.
- pipe_stall hold: read completes while pipe_stall=1 for 4 cycles -> stays in RESP, data_stall=0, mem_rdata constant, RAM untouched. Drop pipe_stall -> IDLE next cycle.
- Flush mid-WAIT: write issued, mem_en dropped at T+1 -> write still committed (verified by later read). RESP lasts exactly 1 cycle.
- LATENCY=1 back-to-back: alternate read/write every cycle pair -> stall pattern 1,0,1,0. Address 0x1010 with ADDR_W=10 aliases to word 4.
